nrow_game_ctrl: RTL

NROW_GAME_CTRL -- requirements
Module: nrow_game_ctrl

---
 rtl/nrow_game_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/nrow_game_ctrl.sv
// N-in-a-row board game controller.
// Holds a BOARD_N x BOARD_N board, validates moves, and after each legal move
// walks the four line directions around the new stone one neighbour per cycle.
// Every game outcome therefore resolves after the same number of cycles.
module nrow_game_ctrl #(
  parameter int BOARD_N = 3,
  parameter int WIN_LEN = 3,
  localparam int IDX_W = $clog2(BOARD_N * BOARD_N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             new_game,
  input  logic             move_valid,
  input  logic [IDX_W-1:0] move_idx,
  output logic             move_ready,
  output logic             move_err,
  output logic             move_done,
  output logic             turn_o,
  output logic [1:0]       result,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_cell
);

  localparam int CELLS = BOARD_N * BOARD_N;
  localparam logic [IDX_W:0] CELLS_W = (IDX_W+1)'(CELLS);
  localparam logic [3:0] K_LAST = 4'(WIN_LEN - 1);
  localparam logic [4:0] RUN_NEED = 5'(WIN_LEN - 1);
  localparam logic signed [6:0] N_S = 7'(BOARD_N);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_OVER  = 2'd2;

  localparam logic [1:0] C_EMPTY = 2'b00;
  localparam logic [1:0] C_X     = 2'b01;
  localparam logic [1:0] C_O     = 2'b10;

  logic [1:0]       board [CELLS];
  logic [1:0]       state;
  logic [IDX_W:0]   move_cnt;

  // Scan context: position of the stone being evaluated and walk counters.
  logic [3:0]       mv_r;
  logic [3:0]       mv_c;
  logic [1:0]       dir;
  logic             side;       // 0 = negative side, 1 = positive side
  logic [3:0]       step_k;     // neighbour distance 1..WIN_LEN-1
  logic             run;        // current side still matching
  logic [4:0]       dir_cnt;    // matches found in current direction
  logic             win;
  logic             scan_done;

  logic             clear;
  logic             accept;
  logic             idx_oob;
  logic [1:0]       tgt_cell;
  logic             legal;
  logic [1:0]       mover;

  logic signed [6:0] k_s;
  logic signed [6:0] dr;
  logic signed [6:0] dc;
  logic signed [6:0] tr;
  logic signed [6:0] tc;
  logic              in_b;
  int                nb_lin;
  logic [IDX_W-1:0]  nb_idx;
  logic [1:0]        nb_cell;
  logic              hit;
  logic [4:0]        dir_cnt_nx;

  assign clear      = rst | new_game;
  assign move_ready = (state == S_IDLE) && (result == 2'b00);
  assign accept     = move_valid & move_ready & ~new_game;
  assign idx_oob    = {1'b0, move_idx} >= CELLS_W;
  assign tgt_cell   = idx_oob ? C_EMPTY : board[move_idx];
  assign legal      = ~idx_oob & (tgt_cell == C_EMPTY);
  assign mover      = turn_o ? C_O : C_X;
  assign rd_cell    = ({1'b0, rd_idx} < CELLS_W) ? board[rd_idx] : C_EMPTY;

  // Neighbour address for the current scan step and whether it extends the run.
  always_comb begin
    k_s = {3'b000, step_k};
    dr  = '0;
    dc  = '0;
    case (dir)
      2'd0:    begin dr = '0;  dc = k_s;  end
      2'd1:    begin dr = k_s; dc = '0;   end
      2'd2:    begin dr = k_s; dc = k_s;  end
      default: begin dr = k_s; dc = -k_s; end
    endcase
    if (!side) begin
      dr = -dr;
      dc = -dc;
    end
    tr = $signed({3'b000, mv_r}) + dr;
    tc = $signed({3'b000, mv_c}) + dc;
    in_b = (tr >= 7'sd0) && (tr < N_S) && (tc >= 7'sd0) && (tc < N_S);
    nb_lin = int'(tr) * BOARD_N + int'(tc);
    nb_idx = IDX_W'(nb_lin);
    nb_cell = in_b ? board[nb_idx] : C_EMPTY;
    hit = run & in_b & (nb_cell == mover);
    dir_cnt_nx = dir_cnt + {4'b0000, hit};
  end

  // Board storage: cleared on reset/new game, written at the accept edge.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < CELLS; i++) begin
        board[i] <= C_EMPTY;
      end
    end else if (accept && legal) begin
      board[move_idx] <= mover;
    end
  end

  // Game FSM: move acceptance, fixed-length line scan, and result resolution.
  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= S_IDLE;
      turn_o    <= 1'b0;
      result    <= 2'b00;
      move_cnt  <= '0;
      move_err  <= 1'b0;
      move_done <= 1'b0;
      mv_r      <= '0;
      mv_c      <= '0;
      dir       <= '0;
      side      <= 1'b0;
      step_k    <= 4'd1;
      run       <= 1'b1;
      dir_cnt   <= '0;
      win       <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      move_err  <= 1'b0;
      move_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (!legal) begin
              move_err <= 1'b1;
            end else begin
              state     <= S_CHECK;
              move_cnt  <= move_cnt + (IDX_W+1)'(1);
              mv_r      <= 4'(int'(move_idx) / BOARD_N);
              mv_c      <= 4'(int'(move_idx) % BOARD_N);
              dir       <= '0;
              side      <= 1'b0;
              step_k    <= 4'd1;
              run       <= 1'b1;
              dir_cnt   <= '0;
              win       <= 1'b0;
              scan_done <= 1'b0;
            end
          end
        end
        S_CHECK: begin
          if (!scan_done) begin
            if (step_k == K_LAST) begin
              step_k <= 4'd1;
              run    <= 1'b1;
              if (!side) begin
                side    <= 1'b1;
                dir_cnt <= dir_cnt_nx;
              end else begin
                side    <= 1'b0;
                dir_cnt <= '0;
                if (dir_cnt_nx >= RUN_NEED) begin
                  win <= 1'b1;
                end
                if (dir == 2'd3) begin
                  scan_done <= 1'b1;
                end else begin
                  dir <= dir + 2'd1;
                end
              end
            end else begin
              step_k  <= step_k + 4'd1;
              dir_cnt <= dir_cnt_nx;
              if (!hit) begin
                run <= 1'b0;
              end
            end
          end else begin
            move_done <= 1'b1;
            scan_done <= 1'b0;
            if (win) begin
              result <= turn_o ? 2'b10 : 2'b01;
              state  <= S_OVER;
            end else if (move_cnt == CELLS_W) begin
              result <= 2'b11;
              state  <= S_OVER;
            end else begin
              turn_o <= ~turn_o;
              state  <= S_IDLE;
            end
          end
        end
        S_OVER: begin
          state <= S_OVER;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
